// File: rtl/risc_z_pkg.sv
// rtl/risc_z_pkg.sv - shared fetch-stage constants: FSM encoding, NOP, PC defaults
package risc_z_pkg;

    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_ADV  = 2'd1;
    localparam logic [1:0] FETCH_REQ  = 2'd2;
    localparam logic [1:0] FETCH_HOLD = 2'd3;

    localparam logic [15:0] NOP_INSTR    = 16'h0000;
    localparam int          DEF_PC_INC   = 1;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;

    localparam logic [31:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - saturating fetch/stall event counters
module fetch_perf_cnt
    import risc_z_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_inc && (fetch_cnt_q != PERF_CNT_MAX)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (stall_inc && (stall_cnt_q != PERF_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage FSM driving PC register, imem and IR; FETCH_PERF_CNT_EN adds perf counters
module instr_fetch
    import risc_z_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                PC_INC   = DEF_PC_INC,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_next_q, pc_next_d;
    logic              pc_en_q, pc_en_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic              redirect_take;
    logic              fetch_ok;

    assign redirect_take = redirect && (state_q != FETCH_IDLE);
    // An ack only counts once our registered request is actually on the bus.
    assign fetch_ok = (state_q == FETCH_REQ) && imem_req_q && imem_ack && !redirect_take;

    always_comb begin
        state_d     = state_q;
        pc_next_d   = pc_next_q;
        pc_en_d     = 1'b0;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q && stall;

        case (state_q)
            FETCH_IDLE: begin
                pc_next_d  = RESET_PC;
                pc_en_d    = 1'b1;
                imem_req_d = 1'b0;
                state_d    = FETCH_ADV;
            end
            FETCH_ADV: begin
                imem_req_d = 1'b0;
                state_d    = (ir_valid_q && stall) ? FETCH_HOLD : FETCH_REQ;
            end
            FETCH_REQ: begin
                imem_req_d  = 1'b1;
                imem_addr_d = pc_in;
                if (fetch_ok) begin
                    ir_d       = imem_data;
                    ir_pc_d    = pc_in;
                    ir_valid_d = 1'b1;
                    pc_next_d  = pc_in + ADDR_W'(PC_INC);
                    pc_en_d    = 1'b1;
                    imem_req_d = 1'b0;
                    state_d    = FETCH_ADV;
                end
            end
            FETCH_HOLD: begin
                imem_req_d = 1'b0;
                if (!stall) begin
                    state_d = FETCH_ADV;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        if (redirect_take) begin
            pc_next_d  = redirect_pc;
            pc_en_d    = 1'b1;
            ir_valid_d = 1'b0;
            imem_req_d = 1'b0;
            state_d    = FETCH_ADV;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FETCH_IDLE;
            pc_next_q   <= '0;
            pc_en_q     <= 1'b0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            ir_q        <= DATA_W'(NOP_INSTR);
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_next_q   <= pc_next_d;
            pc_en_q     <= pc_en_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
        end
    end

    assign pc_next   = pc_next_q;
    assign pc_en     = pc_en_q;
    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic stall_evt;
    assign stall_evt = ir_valid_q && stall;

    fetch_perf_cnt u_perf_cnt (
        .clk       (clk),
        .resetn    (reset),
        .fetch_inc (fetch_ok),
        .stall_inc (stall_evt),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );
`else
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with a modelled PC register and imem
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc_in;
    logic [15:0] pc_next;
    logic        pc_en;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        stall = 1'b0;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    logic [15:0] pc_reg = 16'h1234;
    int          n_chk = 0;
    int          n_fail = 0;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_next     (pc_next),
        .pc_en       (pc_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // PC register sitting upstream of the fetch stage
    always @(posedge clk) if (pc_en) pc_reg <= pc_next;
    assign pc_in = pc_reg;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        stall;
        logic        pc_en;
        logic [15:0] pc_next;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] ir_pc;
        logic [15:0] ir;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic st, input logic en, input logic [15:0] nxt,
                                input logic rq, input logic [15:0] ad, input logic v,
                                input logic [15:0] ipc);
        vec_t r;
        r.stall = st; r.pc_en = en; r.pc_next = nxt; r.req = rq;
        r.addr = ad; r.valid = v; r.ir_pc = ipc; r.ir = 16'h0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic ack, input logic red, input logic [15:0] rpc);
        stall       = st;
        imem_ack    = ack;
        imem_data   = imem_addr ^ 16'hA5A5;
        redirect    = red;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0);
            n++;
        end
        chk({name, " req reached"}, 80'(imem_req), 80'd1);
    endtask

    initial begin
        logic [15:0] exp_pc;
        int          n_fetch;
        int          exp_stall;

        // zero-wait fetch from reset, then a 5-cycle stall window on the third instruction
        tbl[0]  = mk(0, 1, 16'd0, 0, 16'd0, 0, 16'd0);
        tbl[1]  = mk(0, 0, 16'd0, 0, 16'd0, 0, 16'd0);
        tbl[2]  = mk(0, 0, 16'd0, 1, 16'd0, 0, 16'd0);
        tbl[3]  = mk(0, 1, 16'd1, 0, 16'd0, 1, 16'd0);
        tbl[4]  = mk(0, 0, 16'd1, 0, 16'd0, 0, 16'd0);
        tbl[5]  = mk(0, 0, 16'd1, 1, 16'd1, 0, 16'd0);
        tbl[6]  = mk(0, 1, 16'd2, 0, 16'd1, 1, 16'd1);
        tbl[7]  = mk(0, 0, 16'd2, 0, 16'd1, 0, 16'd1);
        tbl[8]  = mk(0, 0, 16'd2, 1, 16'd2, 0, 16'd1);
        tbl[9]  = mk(0, 1, 16'd3, 0, 16'd2, 1, 16'd2);
        for (int k = 10; k < 15; k++) tbl[k] = mk(1, 0, 16'd3, 0, 16'd2, 1, 16'd2);
        tbl[15] = mk(0, 0, 16'd3, 0, 16'd2, 0, 16'd2);
        tbl[16] = mk(0, 0, 16'd3, 0, 16'd2, 0, 16'd2);
        tbl[17] = mk(0, 0, 16'd3, 1, 16'd3, 0, 16'd2);
        tbl[18] = mk(0, 1, 16'd4, 0, 16'd3, 1, 16'd3);
        for (int k = 3; k < 19; k++) tbl[k].ir = tbl[k].ir_pc ^ 16'hA5A5;

        reset = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        chk("reset outputs", {pc_en, pc_next, imem_req, imem_addr, ir_valid, ir, ir_pc}, 80'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("reset counters", {fetch_cnt, stall_cnt}, 80'd0);
`endif
        reset = 1'b1;

        for (int k = 0; k < 19; k++) begin
            cyc(tbl[k].stall, imem_req, 1'b0, 16'h0);
            chk($sformatf("vec%0d", k),
                {pc_en, pc_next, imem_req, imem_addr, ir_valid, ir, ir_pc},
                {tbl[k].pc_en, tbl[k].pc_next, tbl[k].req, tbl[k].addr,
                 tbl[k].valid, tbl[k].ir, tbl[k].ir_pc});
        end

        // redirect in the same cycle as an ack drops the data
        wait_req("pre-redirect");
        chk("pre-redirect addr", 80'(imem_addr), 80'h0004);
        cyc(1'b0, 1'b1, 1'b1, 16'h0040);
        chk("redirect pc_en/pc_next", {pc_en, pc_next}, {1'b1, 16'h0040});
        chk("redirect drops ack", {ir_valid, imem_req, ir_pc}, {2'b00, 16'h0003});
        wait_req("after redirect");
        chk("redirect target addr", 80'(imem_addr), 80'h0040);
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("fetch at target", {ir_valid, ir, ir_pc, pc_next}, {1'b1, 16'h0040 ^ 16'hA5A5, 16'h0040, 16'h0041});

        // PC wrap at the top of the address space
        cyc(1'b0, 1'b0, 1'b1, 16'hFFFF);
        wait_req("wrap");
        chk("wrap addr", 80'(imem_addr), 80'hFFFF);
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("wrap pc_next", {pc_en, pc_next, ir_pc, ir}, {1'b1, 16'h0000, 16'hFFFF, 16'h5A5A});
        wait_req("post-wrap");
        chk("post-wrap addr", 80'(imem_addr), 80'h0000);

        // reset while a request is outstanding, then a late ack
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        chk("mid-fetch reset", {pc_en, pc_next, imem_req, imem_addr, ir_valid, ir, ir_pc}, 80'd0);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("late ack in idle", {pc_en, pc_next, imem_req, ir_valid, ir}, {1'b1, 16'h0, 1'b0, 1'b0, 16'h0});
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("late ack in adv", {pc_en, imem_req, ir_valid, ir}, {3'b000, 16'h0});

        // randomized run against a transaction-level model of the fetch stream
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        chk("rnd start pulse", {pc_en, pc_next}, {1'b1, 16'h0});
        exp_pc = 16'h0;
        n_fetch = 0;
        exp_stall = 0;
        for (int i = 0; i < 900; i++) begin
            logic        st, ack, red, p_v, p_req;
            logic [15:0] rpc, p_ir, p_irpc;
            red   = ($urandom_range(0, 15) == 0);
            rpc   = 16'($urandom);
            st    = ($urandom_range(0, 2) == 0);
            ack   = imem_req && (i < 300 || $urandom_range(0, 1) == 1);
            p_v   = ir_valid;
            p_req = imem_req;
            p_ir  = ir;
            p_irpc = ir_pc;
            if (imem_req) chk("rnd imem_addr", 80'(imem_addr), 80'(exp_pc));
            if (p_v && st) exp_stall++;
            cyc(st, ack, red, rpc);
            if (red) begin
                chk("rnd redirect pc", {pc_en, pc_next}, {1'b1, rpc});
                chk("rnd redirect clear", {ir_valid, imem_req, ir, ir_pc}, {2'b00, p_ir, p_irpc});
                exp_pc = rpc;
            end else if (ack && p_req) begin
                chk("rnd fetch ir", {ir_valid, ir, ir_pc}, {1'b1, exp_pc ^ 16'hA5A5, exp_pc});
                chk("rnd fetch pc", {pc_en, pc_next, imem_req}, {1'b1, 16'(exp_pc + 16'd1), 1'b0});
                exp_pc = exp_pc + 16'd1;
                n_fetch++;
            end else begin
                chk("rnd no pc_en", 80'(pc_en), 80'd0);
                if (p_v && st)
                    chk("rnd hold ir", {ir_valid, ir, ir_pc}, {1'b1, p_ir, p_irpc});
                else
                    chk("rnd consume", 80'(ir_valid), 80'd0);
            end
        end
        chk("rnd progress", 80'(n_fetch > 20), 80'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", 80'(fetch_cnt), 80'(n_fetch));
        chk("stall_cnt", 80'(stall_cnt), 80'(exp_stall));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
